// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb_pkg
// Description : Shared FSM state codes and default widths for alu_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package alu_arb_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_OPW   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational grant picker; round-robin from last+1, or a plain
//               lowest-index priority encoder when ALU_ARB_FIXED_PRIO_EN is set.
// Revision    : 1.0  initial release
// ============================================================================
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic [IDXW-1:0] last,
`endif
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx
);

    always_comb begin
        logic [IDXW-1:0] w_k;
        idx = '0;
        w_k = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        // Descending scan so the lowest set index is written last and wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_k = IDXW'(i);
            if (req[w_k]) idx = w_k;
        end
`else
        // Descending distance from last so the nearest requester after last wins.
        for (int i = NREQ; i >= 1; i--) begin
            w_k = IDXW'((int'(last) + i) % NREQ);
            if (req[w_k]) idx = w_k;
        end
`endif
        gnt = (|req) ? ({{(NREQ-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU among NREQ requesters with
//               valid/ready requests and held responses. Build macro:
//               ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
// Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int OPW   = DEFAULT_OPW,
    parameter int NREQ  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*WIDTH-1:0] req_b_i,
    input  logic [NREQ*OPW-1:0]  req_op_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [WIDTH-1:0]     rsp_r_o,
    output logic [WIDTH-1:0]     alu_a_o,
    output logic [WIDTH-1:0]     alu_b_o,
    output logic [OPW-1:0]       alu_op_o,
    input  logic [WIDTH-1:0]     alu_r_i,
    output logic                 busy_o
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDXW-1:0]  r_gnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_res;
    logic [NREQ-1:0]  w_gnt_vec;
    logic [IDXW-1:0]  w_idx;
    logic             w_accept;

    assign w_accept = (r_state == ST_IDLE) && (|req_valid_i);

`ifdef ALU_ARB_FIXED_PRIO_EN
    rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_picker (
        .req (req_valid_i),
        .gnt (w_gnt_vec),
        .idx (w_idx)
    );
`else
    logic [IDXW-1:0] r_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= IDXW'(NREQ - 1);
        end else if (w_accept) begin
            r_last <= w_idx;
        end
    end

    rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_picker (
        .req  (req_valid_i),
        .last (r_last),
        .gnt  (w_gnt_vec),
        .idx  (w_idx)
    );
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|req_valid_i) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready_i[r_gnt]) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_res <= '0;
        end else begin
            if (w_accept) begin
                r_gnt <= w_idx;
                r_a   <= req_a_i[w_idx*WIDTH +: WIDTH];
                r_b   <= req_b_i[w_idx*WIDTH +: WIDTH];
                r_op  <= req_op_i[w_idx*OPW +: OPW];
            end
            if (r_state == ST_EXEC) r_res <= alu_r_i;
        end
    end

    // Ready is masked during reset so no requester sees a handshake that reset discards.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        busy_o      = 1'b0;
        case (r_state)
            ST_IDLE: req_ready_o = rst_i ? '0 : w_gnt_vec;
            ST_EXEC: busy_o = 1'b1;
            ST_RESP: begin
                busy_o      = 1'b1;
                rsp_valid_o = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;
            end
            default: ;
        endcase
    end

    assign rsp_r_o  = r_res;
    assign alu_a_o  = r_a;
    assign alu_b_o  = r_b;
    assign alu_op_o = r_op;

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 8-bit `alu` combinational datapath between NREQ requesters. Each requester presents operands and an opcode with a valid/ready handshake. The block arbitrates round-robin, drives registered operands into the ALU, captures the result, and returns it to the winning requester with a response handshake. It sits between the execution-unit clients (decode/sequencer, address-gen) and the `alu` instance.

Parameters:
WIDTH, 8, operand/result width
OPW, 4, opcode width (matches `alu` op_i)
NREQ, 2, number of requesters (2..4)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
req_valid_i  in  NREQ  request valid per requester
req_ready_o  out  NREQ  one-hot accept pulse
req_a_i  in  NREQ*WIDTH  operand A, requester k at bits [k*WIDTH +: WIDTH]
req_b_i  in  NREQ*WIDTH  operand B, same packing
req_op_i  in  NREQ*OPW  opcode, requester k at [k*OPW +: OPW]
rsp_valid_o  out  NREQ  one-hot response valid
rsp_ready_i  in  NREQ  response accept per requester
rsp_r_o  out  WIDTH  result, shared by all requesters, valid only where rsp_valid_o set
alu_a_o  out  WIDTH  to alu a_i
alu_b_o  out  WIDTH  to alu b_i
alu_op_o  out  OPW  to alu op_i
alu_r_i  in  WIDTH  from alu r_o
busy_o  out  1  high in EXEC or RESP

Behaviour:
- Reset (rst_i high at clock edge) sets the following; the reset dominates every other event in the same cycle.
  - state=IDLE
  - all outputs 0
  - operand/op/result registers 0
  - last-grant pointer = NREQ-1, so requester 0 wins first
- Reset mid-transaction discards it; no rsp_valid_o is ever issued for it.
- FSM IDLE:
  - If any req_valid_i is set, pick the winner g = first set bit scanning from last+1 mod NREQ.
  - req_ready_o[g]=1 combinationally this cycle; the handshake completes.
  - Latch a/b/op of g into the alu_*_o registers, set last=g, go to EXEC.
  - With no valid requests, stay in IDLE and keep alu_*_o unchanged.
- EXEC (1 cycle): alu_*_o hold the latched values; capture alu_r_i into the result register, go to RESP.
- RESP:
  - rsp_valid_o[g]=1 and rsp_r_o=result.
  - On rsp_ready_i[g]=1, go to IDLE the next cycle.
  - The response is held indefinitely until accepted; rsp_r_o stays stable while valid.
- req_ready_o is all-zero outside IDLE. No new request is accepted while in EXEC/RESP; throughput is at most 1 op per 3 cycles.
- Latency: accept at edge N, rsp_valid_o high from N+2.
- Requesters must hold req_* stable while valid and unaccepted.
  - Deasserting valid before accept is legal; the request is not taken.
- rsp_ready_i bits of non-granted requesters are ignored.
- Simultaneous requests: round-robin guarantees each waiting requester is served within NREQ grants.
- The ALU result is purely a function of the registered inputs. No arithmetic is performed here; widths pass through unchanged.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, where the lowest index wins. The last-grant pointer is removed.
- Undefined (default): round-robin as above.
- Handshake and latency are identical in both modes.

Decomposition:
- Package alu_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2
  - default WIDTH/OPW localparams
- One sub-module, rr_picker (combinational): inputs req vector + last pointer, outputs one-hot grant + index. Under ALU_ARB_FIXED_PRIO_EN it reduces to a priority encoder.

Test Plan:
- Bench ALU stub behaviour: r = a+b for op 0, a-b for op 1.
- Single request: req0 a=3,b=5,op=0, rsp_ready0=1 -> req_ready_o=01 at cycle 0, rsp_valid_o=01 with rsp_r_o=8 at cycle 2, busy_o low again at cycle 3.
- Contention: both valid continuously, req0 op=0 a=3 b=5, req1 op=1 a=9 b=4 -> grants alternate 0,1,0,1. Responses are 8 to req0 and 5 to req1 (fixed-priority build: req0 every time).
- Backpressure: rsp_ready0 low for 4 cycles -> rsp_valid_o=01, rsp_r_o stable, req_ready_o=00 throughout; accept on 5th cycle -> IDLE next cycle.
- Reset mid-op: assert rst_i during EXEC -> next cycle all outputs 0. No response is issued. The first grant after reset goes to req0.
- Withdrawn request: req1 valid for 1 cycle while busy, then dropped -> never granted; no rsp_valid_o[1] is issued.
